// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered display data and leading-zero blanking.
// Optional blink support is compiled in when SSD_BLINK_EN is defined.
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 18,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   enable_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    lzb_en,
  input  logic                    load,
  output logic [7:0]              An,
  output logic [7:0]              Cathodes,
  output logic [2:0]              digit_idx,
  output logic                    frame_done
);
  localparam logic [SCAN_DIV-1:0] BLANK = SCAN_DIV'(BLANK_CYCLES);
  localparam logic [2:0]          LAST  = 3'(NUM_DIGITS-1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] dig;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   en;
    logic                    lzb;
  } disp_t;

  disp_t               r_pend, r_disp, w_in;
  logic                r_pflag;
  logic [SCAN_DIV-1:0] r_cnt;
  logic [2:0]          r_idx;
  logic                r_fd;
  logic [7:0]          r_an, r_cath;
  logic                w_term, w_wrap, w_blk, w_lit, w_dark;
  logic [NUM_DIGITS-1:0] w_lzb;
  logic [31:0]         w_dig;
  logic [7:0]          w_dp, w_en, w_lz, w_an, w_cath;
  logic [3:0]          w_nib;
  logic [6:0]          w_seg;

  assign w_term = &r_cnt;
  assign w_wrap = w_term && (r_idx == LAST);
  assign w_in   = {digits_in, dp_in, enable_in, lzb_en};

  // Walk from the top digit down; a digit is blanked while no enabled non-zero digit sits above it.
  always_comb begin
    logic v_zabove;
    w_lzb    = '0;
    v_zabove = 1'b1;
    for (int k = NUM_DIGITS-1; k >= 1; k--) begin
      if (r_disp.dig[4*k +: 4] == 4'd0) w_lzb[k] = r_disp.lzb & v_zabove;
      if (r_disp.en[k] && (r_disp.dig[4*k +: 4] != 4'd0)) v_zabove = 1'b0;
    end
  end

  assign w_dig  = 32'(r_disp.dig);
  assign w_dp   = 8'(r_disp.dp);
  assign w_en   = 8'(r_disp.en);
  assign w_lz   = 8'(w_lzb);
  assign w_nib  = w_dig[{r_idx, 2'b00} +: 4];
  assign w_lit  = w_en[r_idx] & ~w_lz[r_idx] & ~w_blk;
  assign w_dark = (r_cnt < BLANK) | ~w_lit;

  always_comb begin
    w_seg = 7'b1111111;
    case (w_nib)
      4'h0: w_seg = 7'b0000001;  4'h1: w_seg = 7'b1001111;
      4'h2: w_seg = 7'b0010010;  4'h3: w_seg = 7'b0000110;
      4'h4: w_seg = 7'b1001100;  4'h5: w_seg = 7'b0100100;
      4'h6: w_seg = 7'b0100000;  4'h7: w_seg = 7'b0001111;
      4'h8: w_seg = 7'b0000000;  4'h9: w_seg = 7'b0000100;
      4'hA: w_seg = 7'b0001000;  4'hB: w_seg = 7'b1100000;
      4'hC: w_seg = 7'b0110001;  4'hD: w_seg = 7'b1000010;
      4'hE: w_seg = 7'b0110000;  4'hF: w_seg = 7'b0111000;
      default: w_seg = 7'b1111111;
    endcase
  end

  assign w_an   = w_dark ? 8'hFF : ~(8'd1 << r_idx);
  assign w_cath = w_dark ? 8'hFF : {w_seg, ~w_dp[r_idx]};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_fd    <= 1'b0;
      r_pend  <= '0;
      r_pflag <= 1'b0;
      r_disp  <= '0;
      r_an    <= 8'hFF;
      r_cath  <= 8'hFF;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_term) r_idx <= (r_idx == LAST) ? 3'd0 : r_idx + 3'd1;
      r_fd <= w_wrap;
      if (load) r_pend <= w_in;
      // A load coinciding with the frame boundary stays pending for the next frame.
      if (load)        r_pflag <= 1'b1;
      else if (w_wrap) r_pflag <= 1'b0;
      if (w_wrap && r_pflag) r_disp <= r_pend;
      r_an   <= w_an;
      r_cath <= w_cath;
    end
  end

`ifdef SSD_BLINK_EN
  logic [NUM_DIGITS-1:0] r_pblk, r_dblk;
  logic [4:0]            r_frm;
  logic                  r_phase;
  logic [7:0]            w_bk;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pblk  <= '0;
      r_dblk  <= '0;
      r_frm   <= '0;
      r_phase <= 1'b0;
    end else begin
      if (load) r_pblk <= blink_in;
      if (w_wrap && r_pflag) r_dblk <= r_pblk;
      if (w_wrap) begin
        r_frm <= r_frm + 5'd1;
        if (&r_frm) r_phase <= ~r_phase;
      end
    end
  end

  assign w_bk  = 8'(r_dblk);
  assign w_blk = r_phase & w_bk[r_idx];
`else
  logic w_unused_blink;
  assign w_unused_blink = ^blink_in;
  assign w_blk          = 1'b0;
`endif

  assign An         = r_an;
  assign Cathodes   = r_cath;
  assign digit_idx  = r_idx;
  assign frame_done = r_fd;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl (4 digits, 16-clock slots, 2 guard cycles) with a frame-level reference model.
module tb_ssd_scan_ctrl;
  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, enable_in, blink_in;
  logic        lzb_en, load;
  logic [7:0]  An, Cathodes;
  logic [2:0]  digit_idx;
  logic        frame_done;

  ssd_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset), .digits_in(digits_in), .dp_in(dp_in), .enable_in(enable_in),
    .blink_in(blink_in), .lzb_en(lzb_en), .load(load), .An(An), .Cathodes(Cathodes),
    .digit_idx(digit_idx), .frame_done(frame_done));

  always #5 Clk = ~Clk;

  logic [6:0] SEG [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int cmps = 0, errs = 0, prints = 0;
  int n;
  logic [15:0] m_pd, m_dd;
  logic [3:0]  m_pdp, m_ddp, m_pen, m_den, m_pbk, m_dbk;
  logic        m_plz, m_dlz, m_pf;
  logic [7:0]  o_an, o_cath;
  logic [2:0]  o_idx;
  logic        o_fd;

  task automatic model_reset();
    n = 0; m_pf = 0;
    m_pd = 0; m_dd = 0; m_pdp = 0; m_ddp = 0; m_pen = 0; m_den = 0;
    m_pbk = 0; m_dbk = 0; m_plz = 0; m_dlz = 0;
  endtask

  // One clock: outputs reflect the frame position and display contents before the edge.
  task automatic step();
    int cnt, idx;
    bit lit, bnd, zabove;
    logic [3:0] nib;
    logic [7:0] ea, ec;
    @(posedge Clk); #1;
    cnt = n % 16; idx = (n / 16) % 4;
    nib = m_dd[idx*4 +: 4];
    zabove = 1;
    for (int j = idx + 1; j < 4; j++) if (m_den[j] && m_dd[j*4 +: 4] != 0) zabove = 0;
    lit = m_den[idx] && !(m_dlz && idx > 0 && nib == 0 && zabove);
`ifdef SSD_BLINK_EN
    if (((n / 2048) % 2) == 1 && m_dbk[idx]) lit = 0;
`endif
    if (cnt < 2 || !lit) begin ea = 8'hFF; ec = 8'hFF; end
    else begin ea = ~(8'd1 << idx); ec = {SEG[nib], ~m_ddp[idx]}; end
    bnd = (cnt == 15 && idx == 3);
    if (bnd && m_pf) begin
      m_dd = m_pd; m_ddp = m_pdp; m_den = m_pen; m_dbk = m_pbk; m_dlz = m_plz; m_pf = 0;
    end
    if (load) begin
      m_pd = digits_in; m_pdp = dp_in; m_pen = enable_in; m_pbk = blink_in; m_plz = lzb_en; m_pf = 1;
    end
    n++;
    o_an = An; o_cath = Cathodes; o_idx = digit_idx; o_fd = frame_done;
    cmps += 4;
    if (An !== ea || Cathodes !== ec || digit_idx !== 3'((n / 16) % 4) || frame_done !== bnd) begin
      if (An !== ea) errs++;
      if (Cathodes !== ec) errs++;
      if (digit_idx !== 3'((n / 16) % 4)) errs++;
      if (frame_done !== bnd) errs++;
      if (prints < 30) begin
        prints++;
        $display("FAIL model n=%0d An=%b/%b Cath=%b/%b idx=%0d/%0d fd=%b/%b (got/exp)",
                 n, An, ea, Cathodes, ec, digit_idx, (n / 16) % 4, frame_done, bnd);
      end
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en,
                         input logic [3:0] bk, input logic lz);
    digits_in = d; dp_in = dp; enable_in = en; blink_in = bk; lzb_en = lz; load = 1;
    step();
    load = 0;
  endtask

  task automatic wait_fd(input int max, output int k);
    k = 0;
    do begin step(); k++; end while (!o_fd && k < max);
    if (!o_fd) begin
      errs++; cmps++;
      $display("FAIL wait_frame_done timeout after %0d cycles", k);
    end
  endtask

  task automatic test_reset();
    Reset = 0; load = 0;
    for (int i = 0; i < 5; i++) begin
      digits_in = 16'($urandom); dp_in = 4'($urandom); enable_in = 4'($urandom);
      blink_in = 4'($urandom); lzb_en = 1'($urandom); load = 1'($urandom);
      @(posedge Clk); #1;
      cmps++;
      if (An !== 8'hFF || Cathodes !== 8'hFF || digit_idx !== 3'd0 || frame_done !== 1'b0) begin
        errs++;
        $display("FAIL reset An=%h Cath=%h idx=%0d fd=%b, want FF FF 0 0", An, Cathodes, digit_idx, frame_done);
      end
    end
    load = 0; Reset = 1;
    model_reset();
  endtask

  task automatic test_1234();
    int k, lows [4];
    bit bad0, bad3;
    lows = '{0, 0, 0, 0}; bad0 = 0; bad3 = 0;
    do_load(16'h1234, 4'h0, 4'hF, 4'h0, 1'b0);
    wait_fd(200, k);
    for (int i = 0; i < 64; i++) begin
      step();
      for (int d = 0; d < 4; d++) if (o_an == ~(8'd1 << d)) lows[d]++;
      if (o_an == 8'hFE && o_cath != 8'b10011001) bad0 = 1;
      if (o_an == 8'hF7 && o_cath != 8'b10011111) bad3 = 1;
    end
    for (int d = 0; d < 4; d++) begin
      cmps++;
      if (lows[d] != 14) begin errs++; $display("FAIL lit_cycles digit %0d got %0d want 14", d, lows[d]); end
    end
    cmps++; if (bad0) begin errs++; $display("FAIL cath_slot0 got other than 10011001"); end
    cmps++; if (bad3) begin errs++; $display("FAIL cath_slot3 got other than 10011111"); end
  endtask

  task automatic test_lzb();
    int k, dark32;
    bit bad1, bad0;
    dark32 = 0; bad1 = 0; bad0 = 0;
    do_load(16'h0050, 4'h0, 4'hF, 4'h0, 1'b1);
    wait_fd(200, k);
    for (int i = 0; i < 64; i++) begin
      step();
      if (o_an == 8'hF7 || o_an == 8'hFB) dark32++;
      if (o_an == 8'hFD && o_cath != 8'b01001001) bad1 = 1;
      if (o_an == 8'hFE && o_cath != 8'b00000011) bad0 = 1;
    end
    cmps++; if (dark32 != 0) begin errs++; $display("FAIL lzb_dark slots3/2 lit %0d cycles want 0", dark32); end
    cmps++; if (bad1) begin errs++; $display("FAIL lzb_slot1 cath not 01001001"); end
    cmps++; if (bad0) begin errs++; $display("FAIL lzb_slot0 cath not 00000011"); end
  endtask

  task automatic test_back_to_back();
    int k, seen_a, lit_b, bad_b;
    seen_a = 0; lit_b = 0; bad_b = 0;
    do_load(16'h1234, 4'h0, 4'hF, 4'h0, 1'b0);
    wait_fd(200, k);
    k = 0;
    while (o_idx != 3'd2 && k < 100) begin step(); k++; end
    do_load(16'hAAAA, 4'h0, 4'hF, 4'h0, 1'b0);
    k = 0;
    while (o_idx != 3'd3 && k < 100) begin step(); k++; if (o_cath == 8'b00010001) seen_a++; end
    do_load(16'hBBBB, 4'h0, 4'hF, 4'h0, 1'b0);
    k = 0;
    while (!o_fd && k < 100) begin step(); k++; if (o_cath == 8'b00010001) seen_a++; end
    for (int i = 0; i < 64; i++) begin
      step();
      if (o_cath == 8'b00010001) seen_a++;
      if (o_an != 8'hFF) begin lit_b++; if (o_cath != 8'b11000001) bad_b++; end
    end
    cmps++; if (seen_a != 0) begin errs++; $display("FAIL b2b_no_A saw A for %0d cycles want 0", seen_a); end
    cmps++; if (lit_b != 56) begin errs++; $display("FAIL b2b_lit got %0d want 56", lit_b); end
    cmps++; if (bad_b != 0) begin errs++; $display("FAIL b2b_B_cath wrong on %0d cycles want 0", bad_b); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      digits_in = 16'($urandom); dp_in = 4'($urandom); enable_in = 4'($urandom);
      blink_in = 4'($urandom); lzb_en = 1'($urandom);
      if ($urandom_range(0, 3) == 0) digits_in = digits_in & 16'h00FF;
      load = ($urandom_range(0, 29) == 0);
      step();
    end
    load = 0;
  endtask

  task automatic test_blink();
    int k, f0, f123;
    bit l0, l1, l2, l3;
    f0 = 0; f123 = 0;
    do_load(16'h1234, 4'h0, 4'hF, 4'b0001, 1'b0);
    wait_fd(200, k);
    for (int f = 0; f < 64; f++) begin
      l0 = 0; l1 = 0; l2 = 0; l3 = 0;
      for (int i = 0; i < 64; i++) begin
        step();
        if (o_an == 8'hFE) l0 = 1;
        if (o_an == 8'hFD) l1 = 1;
        if (o_an == 8'hFB) l2 = 1;
        if (o_an == 8'hF7) l3 = 1;
      end
      if (l0) f0++;
      if (l1 && l2 && l3) f123++;
    end
    cmps++;
`ifdef SSD_BLINK_EN
    if (f0 != 32) begin errs++; $display("FAIL blink_digit0 lit in %0d of 64 frames want 32", f0); end
`else
    if (f0 != 64) begin errs++; $display("FAIL blink_digit0 lit in %0d of 64 frames want 64", f0); end
`endif
    cmps++; if (f123 != 64) begin errs++; $display("FAIL blink_digits123 lit in %0d of 64 frames want 64", f123); end
  endtask

  task automatic test_mid_reset();
    int k;
    k = 0;
    while (!((n % 16) == 7 && ((n / 16) % 4) == 2) && k < 200) begin step(); k++; end
    cmps++; if (o_an !== 8'hFB) begin errs++; $display("FAIL pre_reset_lit An=%b want 11111011", o_an); end
    #3 Reset = 0;
    #1;
    cmps++;
    if (An !== 8'hFF || Cathodes !== 8'hFF || digit_idx !== 3'd0 || frame_done !== 1'b0) begin
      errs++;
      $display("FAIL async_reset An=%h Cath=%h idx=%0d fd=%b want FF FF 0 0", An, Cathodes, digit_idx, frame_done);
    end
    @(posedge Clk); #1;
    Reset = 1;
    model_reset();
    wait_fd(100, k);
    cmps++; if (k != 64) begin errs++; $display("FAIL first_frame_done after %0d cycles want 64", k); end
  endtask

  initial begin
    digits_in = 0; dp_in = 0; enable_in = 0; blink_in = 0; lzb_en = 0; load = 0;
    model_reset();
    test_reset();
    test_1234();
    test_lzb();
    test_back_to_back();
    test_random();
    test_blink();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of scanned digits (legal 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 18, digit slot length of 2^SCAN_DIV clocks.
REQ-003 SHALL have parameter BLANK_CYCLES, default 64, anode-off guard cycles at the start of each slot (legal 0..2^SCAN_DIV-1).
REQ-004 SHALL have the following ports:
  Clk  input  1  system clock, rising edge, single clock domain.
  Reset  input  1  asynchronous, active-low reset.
  digits_in  input  4*NUM_DIGITS  hex nibble per digit, digit k at [4k+3:4k].
  dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
  enable_in  input  NUM_DIGITS  digit enable, 0 = digit dark.
  blink_in  input  NUM_DIGITS  per-digit blink request.
  lzb_en  input  1  leading-zero blanking enable.
  load  input  1  one-cycle strobe capturing digits_in/dp_in/enable_in/blink_in/lzb_en.
  An  output  8  anodes, active low, An[k] = digit k.
  Cathodes  output  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active low.
  digit_idx  output  3  index of the slot currently scanned.
  frame_done  output  1  one-cycle pulse at end of slot NUM_DIGITS-1.

Function
REQ-005 SHALL hold a slot counter 0..2^SCAN_DIV-1; at terminal count it wraps to 0 and digit_idx increments, wrapping from NUM_DIGITS-1 to 0.
REQ-006 SHALL assert frame_done for exactly the cycle in which digit_idx wraps to 0.
REQ-007 SHALL capture inputs into a pending register on load; if load recurs before transfer, the latest capture wins.
REQ-008 SHALL transfer pending to the display register only at the frame boundary (cycle digit_idx wraps to 0), so a frame never mixes old and new values.
REQ-009 SHALL drive all An bits high while slot counter < BLANK_CYCLES.
REQ-010 SHALL otherwise drive An[digit_idx] low iff digit enabled, not LZB-blanked, not blink-blanked; all other An bits high.
REQ-011 SHALL hold An[7:NUM_DIGITS] high at all times.
REQ-012 LZB: with lzb_en=1, digit k (k>=1) SHALL be blanked when its nibble and every higher enabled nibble are 0; digit 0 is never LZB-blanked; a blanked digit's Dp is also dark.
REQ-013 Cathodes SHALL use this segment map (abcdefg, active low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000; Dp = ~dp bit.
REQ-014 Cathodes SHALL be 8'hFF whenever all anodes are high.
REQ-015 An, Cathodes, digit_idx, frame_done SHALL be registered; An/Cathodes lag slot counter state by exactly 1 cycle.

Reset
REQ-016 While Reset=0: An=8'hFF, Cathodes=8'hFF, digit_idx=0, frame_done=0, slot counter=0, pending and display registers=0, pending flag=0.
REQ-017 Reset asserted mid-slot SHALL take effect immediately (asynchronously); after release scanning restarts at digit 0, slot counter 0, display dark until first load transfers.

Configuration
REQ-018 Macro SSD_BLINK_EN defined: a frame counter SHALL toggle blink phase every 32 frames; during phase 1, digits with blink bit set are blanked (anode high, Cathodes 8'hFF).
REQ-019 SSD_BLINK_EN undefined: blink_in SHALL be ignored and no frame counter implemented; behaviour otherwise identical.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=2)
REQ-020 Reset=0 for 5 cycles with random inputs -> An=8'hFF, Cathodes=8'hFF, digit_idx=0, frame_done=0 throughout.
REQ-021 load digits_in=16'h1234, enable_in=4'hF, dp_in=0 -> from next frame, An cycles 11111110/11111101/11111011/11110111, each low 14 cycles after 2 dark; slot 0 Cathodes=8'b10011001, slot 3 Cathodes=8'b10011111.
REQ-022 load digits_in=16'h0050, lzb_en=1, enable_in=4'hF -> slots 3,2 dark; slot 1 Cathodes=8'b01001001; slot 0 Cathodes=8'b00000011.
REQ-023 load 16'hAAAA while digit_idx=2, then load 16'hBBBB at digit_idx=3 -> remainder of frame shows old values; next frame shows B (Cathodes=8'b11000001), never A.
REQ-024 SSD_BLINK_EN defined, blink_in=4'b0001, 16'h1234 enabled -> digit 0 lit 32 frames, dark 32 frames, repeating; digits 1-3 always lit; undefined -> digit 0 always lit.
REQ-025 Reset pulsed low at slot counter 7 of digit 2 -> An=8'hFF same cycle; after release digit_idx=0, frame_done first pulses 64 cycles later, display dark until a load transfers.
